vram_arbiter: RTL and testbench

- Shares the single-port, 16-bit synchronous VRAM between two requesters: display scanout and the CPU bus.
- Display fetch has absolute priority and fixed 1-cycle read latency, so the scanout pipeline timing never changes.
- CPU accesses use a req/ack handshake and proceed only in cycles the display leaves free.
- Also exposes a saturating CPU stall counter for performance debug.

---
 rtl/vram_arbiter.sv | 178 +++++++++++++++++
 tb/tb_vram_arbiter.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vram_arbiter.sv
// vram_arbiter: shares one single-port 16-bit synchronous VRAM between display
// scanout (absolute priority, fixed 1-cycle read latency) and a CPU req/ack port.
// The CPU port handles halfword and, when enabled, two-beat word accesses. A
// saturating stall counter records cycles the display blocked the CPU.
// Optional feature macro: VRAM_WORD_ACCESS_EN enables two-beat 32-bit accesses.
// Without it, cpu_word and cpu_be[3:2] are ignored and every access is one beat.
module vram_arbiter #(
    parameter int ADDR_W  = 16,
    parameter int STALL_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               disp_req,
    input  logic [ADDR_W-1:0]  disp_addr,
    output logic [15:0]        disp_rdata,
    input  logic               cpu_req,
    input  logic               cpu_we,
    input  logic               cpu_word,
    input  logic [ADDR_W-1:0]  cpu_addr,
    input  logic [3:0]         cpu_be,
    input  logic [31:0]        cpu_wdata,
    output logic [31:0]        cpu_rdata,
    output logic               cpu_ack,
    input  logic               stall_clr,
    output logic [STALL_W-1:0] stall_cnt,
    output logic [ADDR_W-1:0]  vram_addr,
    output logic               vram_we,
    output logic [1:0]         vram_be,
    output logic [15:0]        vram_wdata,
    input  logic [15:0]        vram_rdata
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HI   = 2'd1,
        ST_FIN  = 2'd2,
        ST_ACK  = 2'd3
    } state_t;

    state_t               state_r;
    state_t               state_nxt_s;
    logic                 word_s;
    logic                 word_r;
    logic                 hi_first_r;
    logic [15:0]          rdata_lo_r;
    logic [31:0]          cpu_rdata_r;
    logic                 cpu_ack_r;
    logic [STALL_W-1:0]   stall_cnt_r;
    logic                 issue0_s;
    logic                 issue1_s;
    logic                 stall_inc_s;
    logic [ADDR_W-1:0]    addr_hi_s;

`ifdef VRAM_WORD_ACCESS_EN
    assign word_s = cpu_word;
`else
    // Word-access inputs have no function in this build.
    logic unused_s;
    assign unused_s = ^{cpu_word, cpu_be[3:2], cpu_wdata[31:16]};
    assign word_s   = 1'b0;
`endif

    // Second beat targets the next halfword; wraps naturally at ADDR_W bits.
    assign addr_hi_s  = cpu_addr + {{(ADDR_W-1){1'b0}}, 1'b1};

    // Scanout data is the raw VRAM output; the display owns its own timing.
    assign disp_rdata = vram_rdata;
    assign cpu_rdata  = cpu_rdata_r;
    assign cpu_ack    = cpu_ack_r;
    assign stall_cnt  = stall_cnt_r;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic: CPU beats only advance in cycles without a display fetch.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (cpu_req && !disp_req) begin
                    state_nxt_s = word_s ? ST_HI : ST_FIN;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_HI: begin
                if (!disp_req) begin
                    state_nxt_s = ST_FIN;
                end else begin
                    state_nxt_s = ST_HI;
                end
            end
            ST_FIN:  state_nxt_s = ST_ACK;
            ST_ACK:  state_nxt_s = ST_IDLE;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Output logic: beat issue decode, VRAM port mux (display first) and stall qualifier.
    always_comb begin
        issue0_s    = (state_r == ST_IDLE) && cpu_req && !disp_req;
        issue1_s    = (state_r == ST_HI) && !disp_req;
        stall_inc_s = disp_req && (((state_r == ST_IDLE) && cpu_req) || (state_r == ST_HI));
        vram_addr   = {ADDR_W{1'b0}};
        vram_we     = 1'b0;
        vram_be     = 2'b00;
        vram_wdata  = 16'h0000;
        if (disp_req) begin
            vram_addr = disp_addr;
            vram_we   = 1'b0;
            vram_be   = 2'b11;
        end else if (issue0_s) begin
            vram_addr  = cpu_addr;
            vram_we    = cpu_we;
            vram_be    = cpu_be[1:0];
            vram_wdata = cpu_wdata[15:0];
        end else if (issue1_s) begin
            vram_addr  = addr_hi_s;
            vram_we    = cpu_we;
            vram_be    = cpu_be[3:2];
            vram_wdata = cpu_wdata[31:16];
        end else begin
            vram_addr  = {ADDR_W{1'b0}};
            vram_we    = 1'b0;
            vram_be    = 2'b00;
            vram_wdata = 16'h0000;
        end
    end

    // CPU datapath: capture read beats one cycle after issue, then present with the ack pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_r      <= 1'b0;
            hi_first_r  <= 1'b0;
            rdata_lo_r  <= 16'h0000;
            cpu_rdata_r <= 32'h0000_0000;
            cpu_ack_r   <= 1'b0;
        end else begin
            cpu_ack_r <= 1'b0;
            if (issue0_s) begin
                word_r     <= word_s;
                hi_first_r <= word_s;
            end else if (state_r == ST_HI) begin
                // Only the first HI cycle holds beat-0 data; later stalled cycles
                // see display data on vram_rdata.
                hi_first_r <= 1'b0;
                if (hi_first_r) begin
                    rdata_lo_r <= vram_rdata;
                end
            end else if (state_r == ST_FIN) begin
                cpu_ack_r   <= 1'b1;
                cpu_rdata_r <= word_r ? {vram_rdata, rdata_lo_r} : {16'h0000, vram_rdata};
            end else begin
                hi_first_r <= 1'b0;
            end
        end
    end

    // Stall counter: saturating, clear has priority over a same-cycle increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_r <= {STALL_W{1'b0}};
        end else if (stall_clr) begin
            stall_cnt_r <= {STALL_W{1'b0}};
        end else if (stall_inc_s && !(&stall_cnt_r)) begin
            stall_cnt_r <= stall_cnt_r + {{(STALL_W-1){1'b0}}, 1'b1};
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed testbench for vram_arbiter with a behavioural 1-cycle-latency VRAM.
// A narrow stall counter is used so saturation is reachable in a few cycles.
module tb_vram_arbiter;
    localparam int ADDR_W  = 16;
    localparam int STALL_W = 4;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               disp_req;
    logic [ADDR_W-1:0]  disp_addr;
    logic [15:0]        disp_rdata;
    logic               cpu_req, cpu_we, cpu_word;
    logic [ADDR_W-1:0]  cpu_addr;
    logic [3:0]         cpu_be;
    logic [31:0]        cpu_wdata, cpu_rdata;
    logic               cpu_ack;
    logic               stall_clr;
    logic [STALL_W-1:0] stall_cnt;
    logic [ADDR_W-1:0]  vram_addr;
    logic               vram_we;
    logic [1:0]         vram_be;
    logic [15:0]        vram_wdata;
    logic [15:0]        vram_rdata;

    logic               bd_we;
    logic [ADDR_W-1:0]  bd_addr;
    logic [15:0]        bd_data;
    logic [15:0]        mem [0:65535];

    int n_cmp = 0;
    int n_err = 0;
    logic seen_we, seen_ack;

    vram_arbiter #(.ADDR_W(ADDR_W), .STALL_W(STALL_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .disp_req(disp_req), .disp_addr(disp_addr), .disp_rdata(disp_rdata),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_word(cpu_word), .cpu_addr(cpu_addr),
        .cpu_be(cpu_be), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
        .stall_clr(stall_clr), .stall_cnt(stall_cnt),
        .vram_addr(vram_addr), .vram_we(vram_we), .vram_be(vram_be),
        .vram_wdata(vram_wdata), .vram_rdata(vram_rdata)
    );

    always #5 clk = ~clk;

    // VRAM model: byte-enabled write, registered read, plus a backdoor preload port.
    always @(posedge clk) begin
        if (bd_we) begin
            mem[bd_addr] <= bd_data;
        end else if (vram_we) begin
            if (vram_be[0]) mem[vram_addr][7:0]  <= vram_wdata[7:0];
            if (vram_be[1]) mem[vram_addr][15:8] <= vram_wdata[15:8];
        end
        vram_rdata <= mem[vram_addr];
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [ADDR_W-1:0] a, input logic [15:0] d);
        bd_we = 1'b1; bd_addr = a; bd_data = d;
        step();
        bd_we = 1'b0;
    endtask

    task automatic cpu_idle();
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_word = 1'b0;
        cpu_addr = 16'h0000; cpu_be = 4'h0; cpu_wdata = 32'h0000_0000;
    endtask

    task automatic test_reset();
        #3;
        n_cmp++; if (cpu_ack !== 1'b0) begin n_err++; $display("FAIL reset_ack: got %b want 0", cpu_ack); end
        n_cmp++; if (cpu_rdata !== 32'h0) begin n_err++; $display("FAIL reset_rdata: got %h want 0", cpu_rdata); end
        n_cmp++; if (stall_cnt !== 4'h0) begin n_err++; $display("FAIL reset_stall: got %h want 0", stall_cnt); end
        step();
        rst_n = 1'b1;
        step();
        disp_req = 1'b1; disp_addr = 16'h1234;
        #1;
        n_cmp++; if (vram_addr !== 16'h1234) begin n_err++; $display("FAIL disp_addr_mux: got %h want 1234", vram_addr); end
        n_cmp++; if (vram_we !== 1'b0) begin n_err++; $display("FAIL disp_we: got %b want 0", vram_we); end
        n_cmp++; if (vram_be !== 2'b11) begin n_err++; $display("FAIL disp_be: got %b want 11", vram_be); end
        step();
        n_cmp++; if (disp_rdata !== 16'h5A5A) begin n_err++; $display("FAIL disp_rdata: got %h want 5a5a", disp_rdata); end
        n_cmp++; if (cpu_ack !== 1'b0) begin n_err++; $display("FAIL disp_only_ack: got %b want 0", cpu_ack); end
        n_cmp++; if (stall_cnt !== 4'h0) begin n_err++; $display("FAIL disp_only_stall: got %h want 0", stall_cnt); end
        disp_req = 1'b0; disp_addr = 16'h0000;
    endtask

    task automatic test_halfword_read();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_word = 1'b0; cpu_addr = 16'h0100; cpu_be = 4'h3;
        #1;
        n_cmp++; if (vram_addr !== 16'h0100) begin n_err++; $display("FAIL hr_issue_addr: got %h want 0100", vram_addr); end
        n_cmp++; if (vram_we !== 1'b0) begin n_err++; $display("FAIL hr_issue_we: got %b want 0", vram_we); end
        step();
        n_cmp++; if (cpu_ack !== 1'b0) begin n_err++; $display("FAIL hr_ack_early: got %b want 0", cpu_ack); end
        n_cmp++; if (vram_be !== 2'b00) begin n_err++; $display("FAIL hr_fin_idle: got %b want 00", vram_be); end
        step();
        n_cmp++; if (cpu_ack !== 1'b1) begin n_err++; $display("FAIL hr_ack: got %b want 1", cpu_ack); end
        n_cmp++; if (cpu_rdata !== 32'h0000_BEEF) begin n_err++; $display("FAIL hr_rdata: got %h want 0000beef", cpu_rdata); end
        cpu_idle();
        step();
        n_cmp++; if (cpu_ack !== 1'b0) begin n_err++; $display("FAIL hr_ack_pulse: got %b want 0", cpu_ack); end
    endtask

    task automatic test_halfword_write_be();
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_word = 1'b0; cpu_addr = 16'h0300;
        cpu_be = 4'h1; cpu_wdata = 32'h0000_1234;
        #1;
        n_cmp++; if (vram_we !== 1'b1) begin n_err++; $display("FAIL hw_we: got %b want 1", vram_we); end
        n_cmp++; if (vram_be !== 2'b01) begin n_err++; $display("FAIL hw_be: got %b want 01", vram_be); end
        n_cmp++; if (vram_wdata !== 16'h1234) begin n_err++; $display("FAIL hw_wdata: got %h want 1234", vram_wdata); end
        step(); step();
        n_cmp++; if (cpu_ack !== 1'b1) begin n_err++; $display("FAIL hw_ack: got %b want 1", cpu_ack); end
        cpu_idle();
        step();
        n_cmp++; if (mem[16'h0300] !== 16'hAA34) begin n_err++; $display("FAIL hw_mem: got %h want aa34", mem[16'h0300]); end
    endtask

    task automatic test_stall();
        stall_clr = 1'b1; step(); stall_clr = 1'b0;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_word = 1'b0; cpu_addr = 16'h0400;
        cpu_be = 4'h3; cpu_wdata = 32'h0000_7777;
        disp_req = 1'b1; disp_addr = 16'h0010;
        seen_we = 1'b0; seen_ack = 1'b0;
        repeat (5) begin
            #1;
            if (vram_we) seen_we = 1'b1;
            if (cpu_ack) seen_ack = 1'b1;
            @(posedge clk); #1;
        end
        n_cmp++; if (seen_we !== 1'b0) begin n_err++; $display("FAIL st_no_write: got %b want 0", seen_we); end
        n_cmp++; if (seen_ack !== 1'b0) begin n_err++; $display("FAIL st_no_ack: got %b want 0", seen_ack); end
        n_cmp++; if (stall_cnt !== 4'd5) begin n_err++; $display("FAIL st_count5: got %0d want 5", stall_cnt); end
        stall_clr = 1'b1;
        step();
        n_cmp++; if (stall_cnt !== 4'd0) begin n_err++; $display("FAIL st_clr_wins: got %0d want 0", stall_cnt); end
        stall_clr = 1'b0; disp_req = 1'b0;
        #1;
        n_cmp++; if (vram_we !== 1'b1 || vram_addr !== 16'h0400) begin n_err++; $display("FAIL st_issue: got we=%b addr=%h want we=1 addr=0400", vram_we, vram_addr); end
        step(); step();
        n_cmp++; if (cpu_ack !== 1'b1) begin n_err++; $display("FAIL st_ack: got %b want 1", cpu_ack); end
        cpu_idle();
        step();
        n_cmp++; if (mem[16'h0400] !== 16'h7777) begin n_err++; $display("FAIL st_mem: got %h want 7777", mem[16'h0400]); end
    endtask

    task automatic test_saturation();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_word = 1'b0; cpu_addr = 16'h0100; cpu_be = 4'h3;
        disp_req = 1'b1; disp_addr = 16'h0020;
        repeat (20) step();
        n_cmp++; if (stall_cnt !== 4'hF) begin n_err++; $display("FAIL sat_value: got %h want f", stall_cnt); end
        step();
        n_cmp++; if (stall_cnt !== 4'hF) begin n_err++; $display("FAIL sat_hold: got %h want f", stall_cnt); end
        disp_req = 1'b0;
        step(); step();
        n_cmp++; if (cpu_ack !== 1'b1 || cpu_rdata !== 32'h0000_BEEF) begin n_err++; $display("FAIL sat_access: got ack=%b rdata=%h want ack=1 rdata=0000beef", cpu_ack, cpu_rdata); end
        cpu_idle();
        stall_clr = 1'b1; step(); stall_clr = 1'b0;
    endtask

`ifdef VRAM_WORD_ACCESS_EN
    task automatic test_word_write_wrap();
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_word = 1'b1; cpu_addr = 16'hFFFF;
        cpu_be = 4'hF; cpu_wdata = 32'hCAFE_1234;
        #1;
        n_cmp++; if (vram_addr !== 16'hFFFF || vram_wdata !== 16'h1234 || vram_we !== 1'b1) begin n_err++; $display("FAIL ww_beat0: got addr=%h wd=%h we=%b want ffff 1234 1", vram_addr, vram_wdata, vram_we); end
        step();
        disp_req = 1'b1; disp_addr = 16'h0010;
        seen_we = 1'b0;
        repeat (3) begin
            #1; if (vram_we) seen_we = 1'b1;
            @(posedge clk); #1;
        end
        n_cmp++; if (seen_we !== 1'b0) begin n_err++; $display("FAIL ww_blocked: got %b want 0", seen_we); end
        disp_req = 1'b0;
        #1;
        n_cmp++; if (vram_addr !== 16'h0000 || vram_wdata !== 16'hCAFE || vram_we !== 1'b1 || vram_be !== 2'b11) begin n_err++; $display("FAIL ww_beat1: got addr=%h wd=%h we=%b be=%b want 0000 cafe 1 11", vram_addr, vram_wdata, vram_we, vram_be); end
        n_cmp++; if (stall_cnt !== 4'd3) begin n_err++; $display("FAIL ww_stall: got %0d want 3", stall_cnt); end
        step(); step();
        n_cmp++; if (cpu_ack !== 1'b1) begin n_err++; $display("FAIL ww_ack: got %b want 1", cpu_ack); end
        cpu_idle();
        step();
        n_cmp++; if (mem[16'hFFFF] !== 16'h1234) begin n_err++; $display("FAIL ww_mem_lo: got %h want 1234", mem[16'hFFFF]); end
        n_cmp++; if (mem[16'h0000] !== 16'hCAFE) begin n_err++; $display("FAIL ww_mem_hi: got %h want cafe", mem[16'h0000]); end
        stall_clr = 1'b1; step(); stall_clr = 1'b0;
    endtask

    task automatic test_word_read();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_word = 1'b1; cpu_addr = 16'h0200; cpu_be = 4'hF;
        #1;
        n_cmp++; if (vram_addr !== 16'h0200) begin n_err++; $display("FAIL wr_beat0: got %h want 0200", vram_addr); end
        step();
        n_cmp++; if (vram_addr !== 16'h0201 || vram_be !== 2'b11) begin n_err++; $display("FAIL wr_beat1: got addr=%h be=%b want 0201 11", vram_addr, vram_be); end
        step();
        n_cmp++; if (cpu_ack !== 1'b0) begin n_err++; $display("FAIL wr_ack_early: got %b want 0", cpu_ack); end
        step();
        n_cmp++; if (cpu_ack !== 1'b1 || cpu_rdata !== 32'h2222_1111) begin n_err++; $display("FAIL wr_result: got ack=%b rdata=%h want 1 22221111", cpu_ack, cpu_rdata); end
        cpu_idle();
        step();
    endtask

    task automatic test_reset_mid();
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_word = 1'b1; cpu_addr = 16'h0500;
        cpu_be = 4'hF; cpu_wdata = 32'h9999_8888;
        step();
        disp_req = 1'b1;
        #2;
        rst_n = 1'b0; cpu_idle(); disp_req = 1'b0;
        #1;
        n_cmp++; if (cpu_ack !== 1'b0 || stall_cnt !== 4'h0) begin n_err++; $display("FAIL rm_async: got ack=%b stall=%h want 0 0", cpu_ack, stall_cnt); end
        step(); step();
        rst_n = 1'b1;
        seen_we = 1'b0; seen_ack = 1'b0;
        repeat (3) begin
            #1; if (vram_we) seen_we = 1'b1; if (cpu_ack) seen_ack = 1'b1;
            @(posedge clk); #1;
        end
        n_cmp++; if (seen_we !== 1'b0 || seen_ack !== 1'b0) begin n_err++; $display("FAIL rm_quiet: got we=%b ack=%b want 0 0", seen_we, seen_ack); end
        n_cmp++; if (mem[16'h0501] !== 16'h5555) begin n_err++; $display("FAIL rm_no_beat1: got %h want 5555", mem[16'h0501]); end
        n_cmp++; if (mem[16'h0500] !== 16'h8888) begin n_err++; $display("FAIL rm_beat0: got %h want 8888", mem[16'h0500]); end
    endtask
`else
    task automatic test_word_ignored();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_word = 1'b1; cpu_addr = 16'h0200; cpu_be = 4'hF;
        #1;
        n_cmp++; if (vram_addr !== 16'h0200 || vram_be !== 2'b11) begin n_err++; $display("FAIL wi_issue: got addr=%h be=%b want 0200 11", vram_addr, vram_be); end
        step();
        n_cmp++; if (vram_be !== 2'b00 || cpu_ack !== 1'b0) begin n_err++; $display("FAIL wi_single_beat: got be=%b ack=%b want 00 0", vram_be, cpu_ack); end
        step();
        n_cmp++; if (cpu_ack !== 1'b1) begin n_err++; $display("FAIL wi_ack: got %b want 1", cpu_ack); end
        n_cmp++; if (cpu_rdata !== 32'h0000_1111) begin n_err++; $display("FAIL wi_rdata: got %h want 00001111", cpu_rdata); end
        cpu_idle();
        step();
    endtask

    task automatic test_reset_mid();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_word = 1'b0; cpu_addr = 16'h0100; cpu_be = 4'h3;
        step();
        #2;
        rst_n = 1'b0; cpu_idle();
        #1;
        n_cmp++; if (cpu_ack !== 1'b0) begin n_err++; $display("FAIL rm_async: got %b want 0", cpu_ack); end
        step(); step();
        rst_n = 1'b1;
        seen_ack = 1'b0;
        repeat (3) begin
            #1; if (cpu_ack) seen_ack = 1'b1;
            @(posedge clk); #1;
        end
        n_cmp++; if (seen_ack !== 1'b0) begin n_err++; $display("FAIL rm_no_ack: got %b want 0", seen_ack); end
        n_cmp++; if (vram_be !== 2'b00) begin n_err++; $display("FAIL rm_idle_port: got %b want 00", vram_be); end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; disp_req = 1'b0; disp_addr = 16'h0000; stall_clr = 1'b0;
        bd_we = 1'b0; bd_addr = 16'h0000; bd_data = 16'h0000;
        cpu_idle();
        preload(16'h1234, 16'h5A5A);
        preload(16'h0100, 16'hBEEF);
        preload(16'h0300, 16'hAAAA);
        preload(16'h0200, 16'h1111);
        preload(16'h0201, 16'h2222);
        preload(16'h0500, 16'h0000);
        preload(16'h0501, 16'h5555);
        preload(16'hFFFF, 16'h0000);
        preload(16'h0000, 16'h0000);
        test_reset();
        test_halfword_read();
        test_halfword_write_be();
        test_stall();
        test_saturation();
`ifdef VRAM_WORD_ACCESS_EN
        test_word_write_wrap();
        test_word_read();
`else
        test_word_ignored();
`endif
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
